// File: rtl/wf_instr_pool_pkg.sv
// Shared defaults and width derivations for the wavefront instruction pool.
// Optional feature macro: WF_POOL_OCC_EN (adds the occ_out port on the top).
package wf_instr_pool_pkg;

  localparam int DEF_NUM_WF = 40;
  localparam int DEF_DEPTH  = 4;
  localparam int DEF_WFID_W = 6;
  localparam int DEF_DATA_W = 64;

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int cnt_width(input int depth);
    return ptr_width(depth) + 1;
  endfunction

  function automatic int rr_index(input int last, input int off, input int n);
    return (last + off) % n;
  endfunction

endpackage

// File: rtl/wf_instr_pool_rr_arbiter.sv
// Round-robin selector: searches from last_grant+1 with wrap, remembers the winner.
module wf_rr_arbiter
  import wf_instr_pool_pkg::*;
#(
  parameter int N     = DEF_NUM_WF,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  output logic [N-1:0]     grant,
  output logic             grant_valid,
  output logic [IDX_W-1:0] grant_idx
);

  logic [IDX_W-1:0] last_grant;

  // NOTE: every output gets a default before the search loop, so no latch is inferred.
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int off = 1; off <= N; off++) begin
      if (!grant_valid && req[rr_index(int'(last_grant), off, N)]) begin
        grant_valid = 1'b1;
        grant_idx   = IDX_W'(rr_index(int'(last_grant), off, N));
        grant[rr_index(int'(last_grant), off, N)] = 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= IDX_W'(N - 1);
    end else if (grant_valid) begin
      last_grant <= grant_idx;
    end
  end

endmodule

// File: rtl/wf_instr_pool.sv
// Per-wavefront instruction queues with reservation, flush and round-robin drain.
// Define WF_POOL_OCC_EN to expose the registered occupancy of every queue on occ_out.
module wf_instr_pool
  import wf_instr_pool_pkg::*;
#(
  parameter int NUM_WF = DEF_NUM_WF,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int WFID_W = DEF_WFID_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reserve_valid,
  input  logic [WFID_W-1:0] reserve_wfid,
  input  logic              wr_valid,
  input  logic [WFID_W-1:0] wr_wfid,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              flush_en,
  input  logic [WFID_W-1:0] flush_wfid,
  input  logic [NUM_WF-1:0] stall_mask,
  output logic              out_valid,
  output logic [WFID_W-1:0] out_wfid,
  output logic [DATA_W-1:0] out_data,
  output logic [NUM_WF-1:0] stop_fetch,
  output logic [NUM_WF-1:0] q_empty
`ifdef WF_POOL_OCC_EN
  ,
  output logic [NUM_WF*cnt_width(DEPTH)-1:0] occ_out
`endif
);

  localparam int PTR_W = ptr_width(DEPTH);
  localparam int CNT_W = cnt_width(DEPTH);
  localparam int IDX_W = (NUM_WF > 1) ? $clog2(NUM_WF) : 1;

  logic [PTR_W-1:0]  rd_ptr [NUM_WF];
  logic [PTR_W-1:0]  wr_ptr [NUM_WF];
  logic [CNT_W-1:0]  occ    [NUM_WF];
  logic [CNT_W-1:0]  rsv    [NUM_WF];
  logic [DATA_W-1:0] mem    [NUM_WF][DEPTH];

  logic [NUM_WF-1:0] flush_hit, rsv_hit, wr_hit, req, grant;
  logic              grant_valid;
  logic [IDX_W-1:0]  grant_idx;

  // A flushed queue takes no reserve, write or read in the flush cycle;
  // out-of-range wfids simply match no queue.
  always_comb begin
    for (int i = 0; i < NUM_WF; i++) begin
      flush_hit[i]  = flush_en && (flush_wfid == WFID_W'(i));
      rsv_hit[i]    = reserve_valid && (reserve_wfid == WFID_W'(i)) &&
                      (rsv[i] != CNT_W'(DEPTH)) && !flush_hit[i];
      wr_hit[i]     = wr_valid && (wr_wfid == WFID_W'(i)) &&
                      (occ[i] != rsv[i]) && !flush_hit[i];
      req[i]        = (occ[i] != '0) && !stall_mask[i] && !flush_hit[i];
      stop_fetch[i] = (rsv[i] == CNT_W'(DEPTH));
      q_empty[i]    = (occ[i] == '0);
    end
  end

  wf_rr_arbiter #(.N(NUM_WF), .IDX_W(IDX_W)) u_arb (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_WF; i++) begin
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
        occ[i]    <= '0;
        rsv[i]    <= '0;
      end
      out_valid <= 1'b0;
      out_wfid  <= '0;
      out_data  <= '0;
    end else begin
      for (int i = 0; i < NUM_WF; i++) begin
        if (flush_hit[i]) begin
          rd_ptr[i] <= '0;
          wr_ptr[i] <= '0;
          occ[i]    <= '0;
          rsv[i]    <= '0;
        end else begin
          if (wr_hit[i]) wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
          if (grant[i])  rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
          occ[i] <= occ[i] + CNT_W'(wr_hit[i]) - CNT_W'(grant[i]);
          rsv[i] <= rsv[i] + CNT_W'(rsv_hit[i]) - CNT_W'(grant[i]);
        end
      end
      out_valid <= grant_valid;
      if (grant_valid) begin
        out_wfid <= WFID_W'(grant_idx);
        out_data <= mem[grant_idx][rd_ptr[grant_idx]];
      end
    end
  end

  // NOTE: the entry storage is deliberately not reset; occ gates every read of it.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_WF; i++) begin
      if (wr_hit[i]) mem[i][wr_ptr[i]] <= wr_data;
    end
  end

`ifdef WF_POOL_OCC_EN
  always_comb begin
    for (int i = 0; i < NUM_WF; i++) begin
      occ_out[i*CNT_W +: CNT_W] = occ[i];
    end
  end
`endif

endmodule

// File: tb/tb_wf_instr_pool.sv
// Directed bench for wf_instr_pool: a vector table for single-queue behaviour
// plus hand-written sequences for arbitration, flush, pointer wrap and reset.
module tb_wf_instr_pool;

  localparam int NUM_WF = 40;
  localparam int WFID_W = 6;
  localparam int DATA_W = 64;
  localparam logic [NUM_WF-1:0] ALL = {NUM_WF{1'b1}};

  logic              clk = 1'b0;
  logic              rst;
  logic              reserve_valid;
  logic [WFID_W-1:0] reserve_wfid;
  logic              wr_valid;
  logic [WFID_W-1:0] wr_wfid;
  logic [DATA_W-1:0] wr_data;
  logic              flush_en;
  logic [WFID_W-1:0] flush_wfid;
  logic [NUM_WF-1:0] stall_mask;
  logic              out_valid;
  logic [WFID_W-1:0] out_wfid;
  logic [DATA_W-1:0] out_data;
  logic [NUM_WF-1:0] stop_fetch;
  logic [NUM_WF-1:0] q_empty;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wf_instr_pool dut (
    .clk           (clk),
    .rst           (rst),
    .reserve_valid (reserve_valid),
    .reserve_wfid  (reserve_wfid),
    .wr_valid      (wr_valid),
    .wr_wfid       (wr_wfid),
    .wr_data       (wr_data),
    .flush_en      (flush_en),
    .flush_wfid    (flush_wfid),
    .stall_mask    (stall_mask),
    .out_valid     (out_valid),
    .out_wfid      (out_wfid),
    .out_data      (out_data),
    .stop_fetch    (stop_fetch),
    .q_empty       (q_empty)
  );

  typedef struct {
    logic              rv;
    logic [WFID_W-1:0] rw;
    logic              wv;
    logic [WFID_W-1:0] ww;
    logic [DATA_W-1:0] wd;
    logic [NUM_WF-1:0] stall;
    logic              ev;
    logic [WFID_W-1:0] ewf;
    logic [DATA_W-1:0] ed;
    logic [NUM_WF-1:0] esf;
    logic [NUM_WF-1:0] eqe;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rv, input logic [WFID_W-1:0] rw,
                       input logic wv, input logic [WFID_W-1:0] ww,
                       input logic [DATA_W-1:0] wd, input logic fe,
                       input logic [WFID_W-1:0] fw, input logic [NUM_WF-1:0] stall);
    reserve_valid = rv;
    reserve_wfid  = rw;
    wr_valid      = wv;
    wr_wfid       = ww;
    wr_data       = wd;
    flush_en      = fe;
    flush_wfid    = fw;
    stall_mask    = stall;
  endtask

  task automatic idle();
    drive(1'b0, '0, 1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  // Inputs change after the falling edge; outputs are sampled on the next falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic vec_t mk(input logic rv, input logic [WFID_W-1:0] rw,
                              input logic wv, input logic [WFID_W-1:0] ww,
                              input logic [DATA_W-1:0] wd, input logic [NUM_WF-1:0] stall,
                              input logic ev, input logic [WFID_W-1:0] ewf,
                              input logic [DATA_W-1:0] ed, input logic [NUM_WF-1:0] esf,
                              input logic [NUM_WF-1:0] eqe);
    vec_t v;
    v.rv = rv; v.rw = rw; v.wv = wv; v.ww = ww; v.wd = wd; v.stall = stall;
    v.ev = ev; v.ewf = ewf; v.ed = ed; v.esf = esf; v.eqe = eqe;
    return v;
  endfunction

  initial begin
    logic [NUM_WF-1:0] b3, b5;
    int got;
    b3 = '0; b3[3] = 1'b1;
    b5 = '0; b5[5] = 1'b1;

    // WF3: four reservations fill it, the fifth is ignored; writes into the
    // reservations, an unreserved write is dropped, then the queue drains in order.
    tbl.push_back(mk(1, 3, 0, 0, 0, '0, 0, 0, 0, '0, ALL));
    tbl.push_back(mk(1, 3, 0, 0, 0, '0, 0, 0, 0, '0, ALL));
    tbl.push_back(mk(1, 3, 0, 0, 0, '0, 0, 0, 0, '0, ALL));
    tbl.push_back(mk(1, 3, 0, 0, 0, '0, 0, 0, 0, b3, ALL));
    tbl.push_back(mk(1, 3, 0, 0, 0, '0, 0, 0, 0, b3, ALL));
    tbl.push_back(mk(0, 0, 1, 3, 64'hD0, b3, 0, 0, 0, b3, ALL & ~b3));
    tbl.push_back(mk(0, 0, 1, 3, 64'hD1, b3, 0, 0, 0, b3, ALL & ~b3));
    tbl.push_back(mk(0, 0, 1, 3, 64'hD2, b3, 0, 0, 0, b3, ALL & ~b3));
    tbl.push_back(mk(0, 0, 1, 3, 64'hD3, b3, 0, 0, 0, b3, ALL & ~b3));
    tbl.push_back(mk(0, 0, 1, 3, 64'hD4, b3, 0, 0, 0, b3, ALL & ~b3));
    tbl.push_back(mk(0, 0, 0, 0, 0, '0, 1, 3, 64'hD0, '0, ALL & ~b3));
    tbl.push_back(mk(0, 0, 0, 0, 0, '0, 1, 3, 64'hD1, '0, ALL & ~b3));
    tbl.push_back(mk(0, 0, 0, 0, 0, '0, 1, 3, 64'hD2, '0, ALL & ~b3));
    tbl.push_back(mk(0, 0, 0, 0, 0, '0, 1, 3, 64'hD3, '0, ALL));
    tbl.push_back(mk(0, 0, 1, 3, 64'hD5, '0, 0, 3, 64'hD3, '0, ALL));
    tbl.push_back(mk(0, 0, 0, 0, 0, '0, 0, 3, 64'hD3, '0, ALL));
    // WF2 write with no reservation, then out-of-range wfids.
    tbl.push_back(mk(0, 0, 1, 2, 64'hD6, '0, 0, 3, 64'hD3, '0, ALL));
    tbl.push_back(mk(0, 0, 0, 0, 0, '0, 0, 3, 64'hD3, '0, ALL));
    tbl.push_back(mk(1, 45, 0, 0, 0, '0, 0, 3, 64'hD3, '0, ALL));
    tbl.push_back(mk(0, 0, 1, 45, 64'hD7, '0, 0, 3, 64'hD3, '0, ALL));
    tbl.push_back(mk(0, 0, 0, 0, 0, '0, 0, 3, 64'hD3, '0, ALL));

    rst = 1'b1;
    idle();
    tick();
    tick();
    rst = 1'b0;
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset out_wfid", 64'(out_wfid), 64'd0);
    check("reset out_data", out_data, 64'd0);
    check("reset stop_fetch", 64'(stop_fetch), 64'd0);
    check("reset q_empty", 64'(q_empty), 64'(ALL));

    foreach (tbl[i]) begin
      drive(tbl[i].rv, tbl[i].rw, tbl[i].wv, tbl[i].ww, tbl[i].wd, 1'b0, '0, tbl[i].stall);
      tick();
      check($sformatf("row%0d out_valid", i), 64'(out_valid), 64'(tbl[i].ev));
      check($sformatf("row%0d out_wfid", i), 64'(out_wfid), 64'(tbl[i].ewf));
      check($sformatf("row%0d out_data", i), out_data, tbl[i].ed);
      check($sformatf("row%0d stop_fetch", i), 64'(stop_fetch), 64'(tbl[i].esf));
      check($sformatf("row%0d q_empty", i), 64'(q_empty), 64'(tbl[i].eqe));
    end

    // Round robin: WF0 then WF1, each one edge apart.
    drive(1, 0, 0, 0, 0, 0, 0, '0); tick();
    drive(1, 1, 0, 0, 0, 0, 0, '0); tick();
    drive(0, 0, 1, 0, 64'hA0, 0, 0, '0); tick();
    check("rr write0 out_valid", 64'(out_valid), 64'd0);
    check("rr write0 q_empty0", 64'(q_empty[0]), 64'd0);
    drive(0, 0, 1, 1, 64'hA1, 0, 0, '0); tick();
    check("rr first out_valid", 64'(out_valid), 64'd1);
    check("rr first out_wfid", 64'(out_wfid), 64'd0);
    check("rr first out_data", out_data, 64'hA0);
    idle(); tick();
    check("rr second out_valid", 64'(out_valid), 64'd1);
    check("rr second out_wfid", 64'(out_wfid), 64'd1);
    check("rr second out_data", out_data, 64'hA1);
    tick();
    check("rr drained out_valid", 64'(out_valid), 64'd0);

    // Flush WF5 in the cycle it would be granted, with a same-cycle reserve.
    for (int k = 0; k < 4; k++) begin
      drive(1, 5, 0, 0, 0, 0, 0, '0); tick();
    end
    check("flush pre stop_fetch5", 64'(stop_fetch[5]), 64'd1);
    drive(0, 0, 1, 5, 64'hB0, 0, 0, b5); tick();
    drive(0, 0, 1, 5, 64'hB1, 0, 0, b5); tick();
    check("flush pre q_empty5", 64'(q_empty[5]), 64'd0);
    drive(1, 5, 0, 0, 0, 1, 5, '0); tick();
    check("flush out_valid", 64'(out_valid), 64'd0);
    check("flush q_empty5", 64'(q_empty[5]), 64'd1);
    check("flush stop_fetch5", 64'(stop_fetch[5]), 64'd0);
    drive(0, 0, 1, 5, 64'hB2, 0, 0, '0); tick();
    check("flush post out_valid", 64'(out_valid), 64'd0);
    idle(); tick();
    check("flush dropped write out_valid", 64'(out_valid), 64'd0);
    check("flush dropped write q_empty", 64'(q_empty), 64'(ALL));

    // Stream 9 entries through WF7 with reserve, write and read overlapping.
    got = 0;
    drive(1, 7, 0, 0, 0, 0, 0, '0); tick();
    for (int k = 0; k < 13; k++) begin
      if (k < 9) drive(k < 8, 7, 1, 7, 64'hC000 + 64'(k), 0, 0, '0);
      else idle();
      tick();
      if (out_valid) begin
        check($sformatf("stream%0d out_wfid", got), 64'(out_wfid), 64'd7);
        check($sformatf("stream%0d out_data", got), out_data, 64'hC000 + 64'(got));
        got++;
      end
    end
    check("stream count", 64'(got), 64'd9);
    check("stream q_empty", 64'(q_empty), 64'(ALL));

    // WF0 stalled while WF1 drains, then reset in the middle of WF0.
    drive(1, 0, 0, 0, 0, 0, 0, '0); tick();
    drive(1, 0, 0, 0, 0, 0, 0, '0); tick();
    drive(1, 1, 0, 0, 0, 0, 0, '0); tick();
    drive(1, 1, 0, 0, 0, 0, 0, '0); tick();
    drive(0, 0, 1, 0, 64'hE0, 0, 0, 40'h3); tick();
    drive(0, 0, 1, 0, 64'hE1, 0, 0, 40'h3); tick();
    drive(0, 0, 1, 1, 64'hE2, 0, 0, 40'h3); tick();
    drive(0, 0, 1, 1, 64'hE3, 0, 0, 40'h3); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 40'h1); tick();
    check("stall first out_wfid", 64'(out_wfid), 64'd1);
    check("stall first out_data", out_data, 64'hE2);
    tick();
    check("stall second out_valid", 64'(out_valid), 64'd1);
    check("stall second out_wfid", 64'(out_wfid), 64'd1);
    check("stall second out_data", out_data, 64'hE3);
    tick();
    check("stall blocked out_valid", 64'(out_valid), 64'd0);
    check("stall blocked out_wfid", 64'(out_wfid), 64'd1);
    idle(); tick();
    check("unstall out_valid", 64'(out_valid), 64'd1);
    check("unstall out_wfid", 64'(out_wfid), 64'd0);
    check("unstall out_data", out_data, 64'hE0);
    rst = 1'b1;
    drive(1, 0, 1, 0, 64'hE4, 0, 0, '0); tick();
    rst = 1'b0;
    check("midrst out_valid", 64'(out_valid), 64'd0);
    check("midrst out_data", out_data, 64'd0);
    check("midrst q_empty", 64'(q_empty), 64'(ALL));
    check("midrst stop_fetch", 64'(stop_fetch), 64'd0);
    idle(); tick();
    check("postrst out_valid", 64'(out_valid), 64'd0);
    check("postrst q_empty", 64'(q_empty), 64'(ALL));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
